// File: rtl/ahb_sram_bridge_if.sv
// AHB-Lite slave bus plus DM single-port SRAM signals for ahb_sram_bridge.
// The slave modport is the bridge side; the master modport is the interconnect/SRAM side.
interface ahb_sram_bridge_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [31:0]       HWDATA;
    logic              HREADY;
    logic              HREADYOUT;
    logic              HRESP;
    logic [31:0]       HRDATA;

    logic              DM_enable;
    logic              DM_write;
    logic [ADDR_W-1:0] DM_address;
    logic [31:0]       DM_in;
    logic [31:0]       DM_out;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, DM_out,
        output HREADYOUT, HRESP, HRDATA, DM_enable, DM_write, DM_address, DM_in
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, DM_out,
        input  HREADYOUT, HRESP, HRDATA, DM_enable, DM_write, DM_address, DM_in
    );
endinterface

// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave to single-port synchronous SRAM (DM) bridge with read-modify-write for sub-word stores.
// Define AHB_SRAM_BRIDGE_ERR_EN to return a two-cycle ERROR for misaligned, oversize or out-of-range transfers.
module ahb_sram_bridge #(
    parameter int unsigned        ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = 32'h0001_0000,
    parameter int unsigned        SIZE_BYTES = 262144
) (
    input  logic              clk,
    input  logic              rst,
    ahb_sram_bridge_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WR_WORD,
        RD_WAIT,
        RD_DONE,
        RMW_RD,
        RMW_WR
`ifdef AHB_SRAM_BRIDGE_ERR_EN
        ,
        ERR1,
        ERR2
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic              write_q, write_d;

    logic              accept;
    logic [31:0]       merged;
    logic              hreadyout, hresp, dm_enable, dm_write;
    logic [31:0]       hrdata, dm_in;

`ifdef AHB_SRAM_BRIDGE_ERR_EN
    localparam logic [ADDR_W:0] END_ADDR = {1'b0, BASE_ADDR} + (ADDR_W+1)'(SIZE_BYTES);
    logic bad_xfer;

    always_comb begin
        bad_xfer = (bus.HSIZE > 3'd2)
                || ((bus.HSIZE == 3'd1) && bus.HADDR[0])
                || ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00))
                || (bus.HADDR < BASE_ADDR)
                || ({1'b0, bus.HADDR} >= END_ADDR);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    // Wait states always advance; every other state is ready and may accept a new address phase.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        accept  = bus.HSEL && bus.HREADY && bus.HTRANS[1];
        case (state_q)
            RD_WAIT: state_d = RD_DONE;
            RMW_RD:  state_d = RMW_WR;
`ifdef AHB_SRAM_BRIDGE_ERR_EN
            ERR1:    state_d = ERR2;
`endif
            default: begin
                state_d = IDLE;
                if (accept) begin
                    addr_d  = bus.HADDR;
                    size_d  = bus.HSIZE;
                    write_d = bus.HWRITE;
`ifdef AHB_SRAM_BRIDGE_ERR_EN
                    if (bad_xfer)
                        state_d = ERR1;
                    else
`endif
                    if (!bus.HWRITE)
                        state_d = RD_WAIT;
                    else if (bus.HSIZE >= 3'd2)
                        state_d = WR_WORD;
                    else
                        state_d = RMW_RD;
                end
            end
        endcase
    end

    // DM has no byte strobes, so sub-word stores patch the lanes into the word read back in RMW_RD.
    always_comb begin
        merged = bus.DM_out;
        if (size_q == 3'd0)
            merged[{addr_q[1:0], 3'b000} +: 8] = bus.HWDATA[{addr_q[1:0], 3'b000} +: 8];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = bus.HWDATA[{addr_q[1], 4'b0000} +: 16];
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        dm_enable = 1'b0;
        dm_write  = 1'b0;
        dm_in     = '0;
        if (!rst) begin
            case (state_q)
                WR_WORD: begin
                    dm_enable = 1'b1;
                    dm_write  = write_q;
                    dm_in     = bus.HWDATA;
                end
                RD_WAIT: begin
                    dm_enable = 1'b1;
                    hreadyout = 1'b0;
                end
                RD_DONE: hrdata = bus.DM_out;
                RMW_RD: begin
                    dm_enable = 1'b1;
                    hreadyout = 1'b0;
                end
                RMW_WR: begin
                    dm_enable = 1'b1;
                    dm_write  = write_q;
                    dm_in     = merged;
                end
`ifdef AHB_SRAM_BRIDGE_ERR_EN
                ERR1: begin
                    hreadyout = 1'b0;
                    hresp     = 1'b1;
                end
                ERR2: hresp = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign bus.HREADYOUT  = hreadyout;
    assign bus.HRESP      = hresp;
    assign bus.HRDATA     = hrdata;
    assign bus.DM_enable  = dm_enable;
    assign bus.DM_write   = dm_write;
    assign bus.DM_in      = dm_in;
    assign bus.DM_address = dm_enable ? ((addr_q - BASE_ADDR) & ALIGN_MASK) : '0;

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Directed testbench for ahb_sram_bridge: single-slave AHB master plus a behavioural DM SRAM.
// Control outputs are compared as the nibble {HREADYOUT, HRESP, DM_enable, DM_write}.
module tb_ahb_sram_bridge;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst;
    int   compare_count = 0;
    int   fail_count    = 0;
    int   dm_write_count = 0;
    int   writes_before;
    logic [31:0] read_data;
    logic [31:0] mem [0:65535];

    ahb_sram_bridge_if #(.ADDR_W(32)) bus ();

    ahb_sram_bridge #(
        .ADDR_W(32),
        .BASE_ADDR(BASE),
        .SIZE_BYTES(262144)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Only slave on the bus, so the bus-wide ready is this slave's ready.
    assign bus.HREADY = bus.HREADYOUT;

    always @(posedge clk) begin
        if (bus.DM_enable) begin
            if (bus.DM_write) begin
                mem[bus.DM_address[17:2]] <= bus.DM_in;
                dm_write_count <= dm_write_count + 1;
            end else begin
                bus.DM_out <= mem[bus.DM_address[17:2]];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkCtl(input string tag, input logic [3:0] expected);
        checkOutput({tag, ".ctl"}, {28'd0, bus.HREADYOUT, bus.HRESP, bus.DM_enable, bus.DM_write}, {28'd0, expected});
    endtask

    task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic write,
                                 input logic [2:0] size, input logic [31:0] addr);
        bus.HSEL   = sel;
        bus.HTRANS = trans;
        bus.HWRITE = write;
        bus.HSIZE  = size;
        bus.HADDR  = addr;
    endtask

    task automatic idleBus();
        applyStimulus(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Word preload, sub-word write, then word read-back of the same SRAM word.
    task automatic rmwCase(input string tag, input logic [31:0] word_addr, input logic [31:0] pre_data,
                           input logic [31:0] sub_addr, input logic [2:0] sub_size,
                           input logic [31:0] sub_data, input logic [31:0] exp_word,
                           output logic [31:0] rdata);
        applyStimulus(1'b1, 2'b10, 1'b1, 3'd2, word_addr);
        nextCycle();
        bus.HWDATA = pre_data;
        applyStimulus(1'b1, 2'b10, 1'b1, sub_size, sub_addr);
        nextCycle();
        bus.HWDATA = sub_data;
        applyStimulus(1'b1, 2'b10, 1'b0, sub_size, word_addr);
        @(negedge clk);
        checkCtl({tag, ".rmw_rd"}, 4'b0010);
        checkOutput({tag, ".rmw_addr"}, bus.DM_address, word_addr - BASE);
        nextCycle();
        @(negedge clk);
        checkCtl({tag, ".rmw_wr"}, 4'b1011);
        checkOutput({tag, ".merge"}, bus.DM_in, exp_word);
        nextCycle();
        idleBus();
        @(negedge clk);
        checkCtl({tag, ".rd_wait"}, 4'b0010);
        nextCycle();
        @(negedge clk);
        checkCtl({tag, ".rd_done"}, 4'b1000);
        checkOutput({tag, ".rdata"}, bus.HRDATA, exp_word);
        rdata = bus.HRDATA;
        nextCycle();
    endtask

    initial begin
        rst        = 1'b1;
        bus.HWDATA = 32'h0;
        idleBus();
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkCtl("reset", 4'b1000);
        checkOutput("reset.hrdata", bus.HRDATA, 32'h0);
        checkOutput("reset.dm_addr", bus.DM_address, 32'h0);
        checkOutput("reset.dm_in", bus.DM_in, 32'h0);

        // Read accepted, then reset held for two edges while it is pending.
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h10);
        nextCycle();
        rst = 1'b1;
        idleBus();
        writes_before = dm_write_count;
        @(negedge clk);
        checkCtl("rst_mid", 4'b1000);
        checkOutput("rst_mid.dm_addr", bus.DM_address, 32'h0);
        nextCycle();
        @(negedge clk);
        checkCtl("rst_hold", 4'b1000);
        checkOutput("rst_hold.hrdata", bus.HRDATA, 32'h0);
        nextCycle();
        rst = 1'b0;
        checkOutput("rst_no_write", 32'(dm_write_count - writes_before), 32'h0);

        // Word write then back-to-back read of the same word.
        applyStimulus(1'b1, 2'b10, 1'b1, 3'd2, BASE + 32'h8);
        nextCycle();
        bus.HWDATA = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h8);
        @(negedge clk);
        checkCtl("wr_word", 4'b1011);
        checkOutput("wr_word.addr", bus.DM_address, 32'h8);
        checkOutput("wr_word.din", bus.DM_in, 32'hDEAD_BEEF);
        nextCycle();
        idleBus();
        @(negedge clk);
        checkCtl("rd_wait", 4'b0010);
        checkOutput("rd_wait.addr", bus.DM_address, 32'h8);
        nextCycle();
        @(negedge clk);
        checkCtl("rd_done", 4'b1000);
        checkOutput("rd_done.rdata", bus.HRDATA, 32'hDEAD_BEEF);
        nextCycle();

        rmwCase("byte", BASE + 32'h4, 32'h1122_3344, BASE + 32'h6, 3'd0, 32'h00AA_0000,
                32'h11AA_3344, read_data);
        rmwCase("half", BASE + 32'hC, 32'hFFFF_FFFF, BASE + 32'hE, 3'd1, 32'h5566_0000,
                32'h5566_FFFF, read_data);
        checkOutput("half.low", {16'h0, read_data[15:0]}, 32'h0000_FFFF);

        // Pipelined W,W,R,R over words 0x0..0xC: only the two RD_WAIT cycles stall.
        applyStimulus(1'b1, 2'b10, 1'b1, 3'd2, BASE + 32'h0);
        nextCycle();
        bus.HWDATA = 32'hC0FF_EE00;
        applyStimulus(1'b1, 2'b10, 1'b1, 3'd2, BASE + 32'h4);
        @(negedge clk);
        checkCtl("pipe.w0", 4'b1011);
        checkOutput("pipe.w0.addr", bus.DM_address, 32'h0);
        nextCycle();
        bus.HWDATA = 32'hC0FF_EE04;
        applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h8);
        @(negedge clk);
        checkCtl("pipe.w1", 4'b1011);
        checkOutput("pipe.w1.din", bus.DM_in, 32'hC0FF_EE04);
        nextCycle();
        applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'hC);
        @(negedge clk);
        checkCtl("pipe.r0_wait", 4'b0010);
        nextCycle();
        @(negedge clk);
        checkCtl("pipe.r0_done", 4'b1000);
        checkOutput("pipe.r0_data", bus.HRDATA, 32'hDEAD_BEEF);
        nextCycle();
        idleBus();
        @(negedge clk);
        checkCtl("pipe.r1_wait", 4'b0010);
        checkOutput("pipe.r1_addr", bus.DM_address, 32'hC);
        nextCycle();
        @(negedge clk);
        checkCtl("pipe.r1_done", 4'b1000);
        checkOutput("pipe.r1_data", bus.HRDATA, 32'h5566_FFFF);
        nextCycle();

        // Deselected, BUSY and IDLE transfers must not touch the SRAM.
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       applyStimulus(1'b0, 2'b10, 1'b1, 3'd2, BASE + 32'h30);
                1:       applyStimulus(1'b1, 2'b01, 1'b1, 3'd2, BASE + 32'h30);
                default: applyStimulus(1'b1, 2'b00, 1'b0, 3'd2, BASE + 32'h30);
            endcase
            nextCycle();
            idleBus();
            @(negedge clk);
            checkCtl($sformatf("noxfer%0d", i), 4'b1000);
        end
        nextCycle();

        // Misaligned word read at BASE+0x2.
        applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h2);
        nextCycle();
        idleBus();
        @(negedge clk);
`ifdef AHB_SRAM_BRIDGE_ERR_EN
        checkCtl("misalign.err1", 4'b0100);
        nextCycle();
        @(negedge clk);
        checkCtl("misalign.err2", 4'b1100);
`else
        checkCtl("misalign.wait", 4'b0010);
        checkOutput("misalign.addr", bus.DM_address, 32'h0);
        nextCycle();
        @(negedge clk);
        checkCtl("misalign.done", 4'b1000);
        checkOutput("misalign.rdata", bus.HRDATA, 32'hC0FF_EE00);
`endif
        nextCycle();

        // HSIZE=3 write.
        applyStimulus(1'b1, 2'b10, 1'b1, 3'd3, BASE + 32'h10);
        nextCycle();
        idleBus();
        bus.HWDATA = 32'h1234_5678;
        @(negedge clk);
`ifdef AHB_SRAM_BRIDGE_ERR_EN
        checkCtl("size3.err1", 4'b0100);
`else
        checkCtl("size3.word", 4'b1011);
        checkOutput("size3.din", bus.DM_in, 32'h1234_5678);
`endif
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkCtl("final_idle", 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
